br_resolve_bht: RTL and testbench

//  EX-stage branch resolution and next-PC select with a parametrised bimodal branch history table (BHT).

---
 rtl/br_pkg.sv | 41 ++++
 rtl/br_resolve_bht_if.sv | 33 +++
 rtl/bht_sat_table.sv | 47 ++++
 rtl/br_resolve_bht.sv | 121 ++++++++++++
 tb/tb_br_resolve_bht.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/br_pkg.sv
// Shared encodings for EX-stage branch resolution: next-PC select codes, opcodes, funct3, condition helper.
package br_pkg;

  localparam int unsigned PC_SEL_W = 3;
  localparam int unsigned PERF_W   = 32;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned F3_W     = 3;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_RESET   = 3'b000,
    PC_SEL_ALU     = 3'b001,
    PC_SEL_PLUS4   = 3'b010,
    PC_SEL_RESTORE = 3'b100
  } pc_sel_e;

  // ex_inst[6:2] major opcodes
  localparam logic [OPC_W-1:0] OP_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // Comparator flags arrive with signedness already applied, so BLT/BLTU and BGE/BGEU share a test.
  function automatic logic br_cond(input logic [F3_W-1:0] f3, input logic eq, input logic lt);
    logic res;
    res = 1'b0;
    case (f3)
      F3_BEQ:           res = eq;
      F3_BNE:           res = !eq;
      F3_BLT, F3_BLTU:  res = lt;
      F3_BGE, F3_BGEU:  res = !lt;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/br_resolve_bht_if.sv
// Fetch/EX pipeline bus between the core datapath (master) and the branch resolve unit (slave).
interface br_resolve_bht_if
  import br_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic [XLEN-1:0]     if_pc;
  logic                if_pred_taken;
  logic                ex_valid;
  logic [XLEN-1:0]     ex_inst;
  logic [XLEN-1:0]     ex_pc;
  logic                ex_pred_taken;
  logic                br_eq;
  logic                br_lt;
  logic [PC_SEL_W-1:0] pc_sel;
  logic                flush;
  logic                is_br;
  logic                br_taken;
  logic [PERF_W-1:0]   perf_br_cnt;
  logic [PERF_W-1:0]   perf_miss_cnt;

  modport master (
    output if_pc, ex_valid, ex_inst, ex_pc, ex_pred_taken, br_eq, br_lt,
    input  if_pred_taken, pc_sel, flush, is_br, br_taken, perf_br_cnt, perf_miss_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_inst, ex_pc, ex_pred_taken, br_eq, br_lt,
    output if_pred_taken, pc_sel, flush, is_br, br_taken, perf_br_cnt, perf_miss_cnt
  );

endinterface

// File: rtl/bht_sat_table.sv
// Bimodal table of saturating counters: one lookup port with same-cycle update forwarding, one update port.
module bht_sat_table #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_msb_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] upd_cur_c;
  logic [CNT_W-1:0] upd_nxt_c;

  assign upd_cur_c = cnt_q[upd_idx_i];

  // Saturate at both ends instead of wrapping.
  always_comb begin
    upd_nxt_c = upd_cur_c;
    if (upd_taken_i) begin
      if (upd_cur_c != CNT_MAX) upd_nxt_c = upd_cur_c + CNT_W'(1);
    end else begin
      if (upd_cur_c != '0) upd_nxt_c = upd_cur_c - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_nxt_c;
    end
  end

  // Fetch sees the counter as it will be after this cycle's update when both hit the same entry.
  assign rd_msb_o = (upd_en_i && (upd_idx_i == rd_idx_i)) ? upd_nxt_c[CNT_W-1]
                                                          : cnt_q[rd_idx_i][CNT_W-1];

endmodule

// File: rtl/br_resolve_bht.sv
// EX-stage branch/JALR resolution, next-PC select and bimodal BHT training.
// Optional BR_PERF_CNT_EN adds resolved-branch and mispredict counters; otherwise perf outputs read 0.
module br_resolve_bht
  import br_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  br_resolve_bht_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic             rst_n_q;
  logic [OPC_W-1:0] opcode_c;
  logic [F3_W-1:0]  f3_c;
  pc_sel_e          pc_sel_c;
  logic             flush_c;
  logic             is_br_c;
  logic             taken_c;
  logic             mispred_c;
  logic             unused_bits;

  // Reset release is re-timed so the first edge after rst_n rises still selects the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_n_q <= 1'b0;
    else        rst_n_q <= 1'b1;
  end

  assign opcode_c = bus.ex_inst[6:2];
  assign f3_c     = bus.ex_inst[14:12];

  always_comb begin
    pc_sel_c  = PC_SEL_PLUS4;
    flush_c   = 1'b0;
    is_br_c   = 1'b0;
    taken_c   = 1'b0;
    mispred_c = 1'b0;
    if (!rst_n_q) begin
      pc_sel_c = PC_SEL_RESET;
    end else if (bus.ex_valid) begin
      case (opcode_c)
        OP_JALR: begin
          pc_sel_c = PC_SEL_ALU;
          flush_c  = 1'b1;
        end
        OP_BRANCH: begin
          is_br_c = 1'b1;
          taken_c = br_cond(f3_c, bus.br_eq, bus.br_lt);
          if (taken_c && !bus.ex_pred_taken) begin
            pc_sel_c  = PC_SEL_ALU;
            flush_c   = 1'b1;
            mispred_c = 1'b1;
          end else if (!taken_c && bus.ex_pred_taken) begin
            pc_sel_c  = PC_SEL_RESTORE;
            flush_c   = 1'b1;
            mispred_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_sel   = pc_sel_c;
  assign bus.flush    = flush_c;
  assign bus.is_br    = is_br_c;
  assign bus.br_taken = taken_c;

  bht_sat_table #(
    .DEPTH (BHT_DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (bus.if_pc[IDX_W+1:2]),
    .rd_msb_o    (bus.if_pred_taken),
    .upd_en_i    (is_br_c),
    .upd_idx_i   (bus.ex_pc[IDX_W+1:2]),
    .upd_taken_i (taken_c)
  );

`ifdef BR_PERF_CNT_EN
  logic [PERF_W-1:0] perf_br_q;
  logic [PERF_W-1:0] perf_br_d;
  logic [PERF_W-1:0] perf_miss_q;
  logic [PERF_W-1:0] perf_miss_d;

  // Only branch mispredicts count as misses; JALR redirects are expected.
  always_comb begin
    perf_br_d   = perf_br_q + PERF_W'(is_br_c);
    perf_miss_d = perf_miss_q + PERF_W'(mispred_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q   <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_br_q   <= perf_br_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign bus.perf_br_cnt   = perf_br_q;
  assign bus.perf_miss_cnt = perf_miss_q;
`else
  assign bus.perf_br_cnt   = '0;
  assign bus.perf_miss_cnt = '0;
`endif

  // Upper PC bits alias by design; most instruction fields are decoded elsewhere.
  assign unused_bits = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0],
                         bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0],
                         bus.ex_inst[XLEN-1:15], bus.ex_inst[11:7], bus.ex_inst[1:0]};

endmodule

// File: tb/tb_br_resolve_bht.sv
// Directed bench for br_resolve_bht: reset release, branch resolution, BHT training/saturation, forwarding.
module tb_br_resolve_bht;
  import br_pkg::*;

`ifdef BR_PERF_CNT_EN
  localparam logic [31:0] PERF_MASK = '1;
`else
  localparam logic [31:0] PERF_MASK = '0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  br_resolve_bht_if #(.XLEN(32)) bus ();

  br_resolve_bht #(
    .BHT_DEPTH (64),
    .CNT_W     (2),
    .XLEN      (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] br_inst(input logic [2:0] f3);
    return {17'b0, f3, 5'b0, 7'b1100011};
  endfunction

  function automatic logic [31:0] jalr_inst();
    return {17'b0, 3'b000, 5'b0, 7'b1100111};
  endfunction

  // Drive one EX instruction at negedge, check combinational outcome, let the update clock in.
  task automatic step(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                      input logic pred, input logic eq, input logic lt,
                      input logic [2:0] e_sel, input logic e_flush, input logic e_isbr,
                      input logic e_taken);
    @(negedge clk);
    bus.ex_valid      = 1'b1;
    bus.ex_inst       = inst;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pred;
    bus.br_eq         = eq;
    bus.br_lt         = lt;
    #2;
    chk({tag, ".sel"},   32'(bus.pc_sel),   32'(e_sel));
    chk({tag, ".flush"}, 32'(bus.flush),    32'(e_flush));
    chk({tag, ".is_br"}, 32'(bus.is_br),    32'(e_isbr));
    chk({tag, ".taken"}, 32'(bus.br_taken), 32'(e_taken));
    if (e_isbr) exp_br++;
    if (e_isbr && e_flush) exp_miss++;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic e_pred);
    bus.if_pc = pc;
    #1;
    chk(tag, 32'(bus.if_pred_taken), 32'(e_pred));
  endtask

  task automatic perf_chk(input string tag);
    chk({tag, ".perf_br"},   bus.perf_br_cnt,   32'(exp_br) & PERF_MASK);
    chk({tag, ".perf_miss"}, bus.perf_miss_cnt, 32'(exp_miss) & PERF_MASK);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.if_pc         = '0;
    bus.ex_valid      = 1'b0;
    bus.ex_inst       = '0;
    bus.ex_pc         = '0;
    bus.ex_pred_taken = 1'b0;
    bus.br_eq         = 1'b0;
    bus.br_lt         = 1'b0;
    #2;
    chk("rst.sel", 32'(bus.pc_sel), 32'(3'b000));
    chk("rst.flush", 32'(bus.flush), 32'd0);
    perf_chk("rst");

    // Release between edges: first edge after release still reports RESET.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.sel0", 32'(bus.pc_sel), 32'(3'b000));
    @(posedge clk);
    #1;
    chk("rel.sel1", 32'(bus.pc_sel), 32'(3'b010));
    chk("rel.flush", 32'(bus.flush), 32'd0);
    for (int i = 0; i < 64; i++) pred_at("init.pred", 32'(i) << 2, 1'b0);

    // BEQ taken, predicted not-taken: idx1 01->10
    step("beq_t", br_inst(F3_BEQ), 32'h104, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1);
    pred_at("beq_t.pred", 32'h104, 1'b1);
    pred_at("beq_t.alias", 32'h204, 1'b1);
    perf_chk("beq_t");

    // BNE not taken, predicted taken: idx2 01->00
    step("bne_nt", br_inst(F3_BNE), 32'h108, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0);
    pred_at("bne_nt.pred", 32'h108, 1'b0);
    perf_chk("bne_nt");

    step("blt_t", br_inst(F3_BLT), 32'h10C, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1);
    pred_at("blt_t.pred", 32'h10C, 1'b1);
    step("bgeu_nt", br_inst(F3_BGEU), 32'h110, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
    pred_at("bgeu_nt.pred", 32'h110, 1'b0);
    step("bltu_t", br_inst(F3_BLTU), 32'h114, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1);
    pred_at("bltu_t.pred", 32'h114, 1'b1);
    step("f3_010", br_inst(3'b010), 32'h118, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0);
    pred_at("f3_010.pred", 32'h118, 1'b0);
    step("alu_op", 32'h0000_0033, 32'h120, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    pred_at("alu_op.pred", 32'h120, 1'b0);
    perf_chk("mix");

    // Saturation on idx8: 01 -> 10 -> 11 -> 11 -> 11 -> 11
    for (int i = 0; i < 5; i++) begin
      step("sat_up", br_inst(F3_BEQ), 32'h120, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1);
      pred_at("sat_up.pred", 32'h120, 1'b1);
    end
    step("sat_dn0", br_inst(F3_BEQ), 32'h120, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0);
    pred_at("sat_dn0.pred", 32'h120, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step("sat_dn", br_inst(F3_BEQ), 32'h120, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0);
      pred_at("sat_dn.pred", 32'h120, 1'b0);
    end
    step("sat_rise", br_inst(F3_BEQ), 32'h120, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1);
    pred_at("sat_rise.pred", 32'h120, 1'b0);
    perf_chk("sat");

    // JALR: redirect, no training, no branch count (eq=1 would train idx8 if mistaken for BEQ)
    step("jalr", jalr_inst(), 32'h120, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    pred_at("jalr.pred", 32'h120, 1'b0);
    perf_chk("jalr");

    // Same-cycle forwarding on idx9 (counter 01, taken)
    @(negedge clk);
    bus.if_pc         = 32'h124;
    bus.ex_valid      = 1'b1;
    bus.ex_inst       = br_inst(F3_BEQ);
    bus.ex_pc         = 32'h124;
    bus.ex_pred_taken = 1'b0;
    bus.br_eq         = 1'b1;
    #2;
    chk("fwd.pred", 32'(bus.if_pred_taken), 32'd1);
    chk("fwd.sel", 32'(bus.pc_sel), 32'(3'b001));
    exp_br++;
    exp_miss++;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    #1;
    chk("fwd.after", 32'(bus.if_pred_taken), 32'd1);

    // ex_valid low: no forwarding, no update on idx10
    @(negedge clk);
    bus.if_pc = 32'h128;
    bus.ex_pc = 32'h128;
    #2;
    chk("inval.pred", 32'(bus.if_pred_taken), 32'd0);
    chk("inval.sel", 32'(bus.pc_sel), 32'(3'b010));
    chk("inval.is_br", 32'(bus.is_br), 32'd0);
    @(posedge clk);
    #1;
    pred_at("inval.after", 32'h128, 1'b0);
    perf_chk("fwd");

    // Async reset with an update pending
    @(negedge clk);
    bus.ex_valid      = 1'b1;
    bus.ex_inst       = br_inst(F3_BEQ);
    bus.ex_pc         = 32'h104;
    bus.ex_pred_taken = 1'b1;
    bus.br_eq         = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.sel", 32'(bus.pc_sel), 32'(3'b000));
    chk("mrst.is_br", 32'(bus.is_br), 32'd0);
    chk("mrst.flush", 32'(bus.flush), 32'd0);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    exp_br   = 0;
    exp_miss = 0;
    perf_chk("mrst");
    pred_at("mrst.pred1", 32'h104, 1'b0);
    pred_at("mrst.pred3", 32'h10C, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.rel", 32'(bus.pc_sel), 32'(3'b010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
